// File: rtl/expr_eval.sv
// expr_eval: streaming ASCII arithmetic expression evaluator.
// Honours '*' over '+'/'-' precedence using sum/product/operand registers.
module expr_eval #(
    parameter int WIDTH      = 32,
    parameter int MAX_DIGITS = 4,
    parameter int ALLOW_SUB  = 1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [7:0]       in,
    output logic             out,
    output logic [WIDTH-1:0] value,
    output logic             err
);

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [WIDTH-1:0] TEN = WIDTH'(10);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        NUM  = 4'b0010,
        OP   = 4'b0100,
        ERR  = 4'b1000
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic             neg_q, neg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             out_q, out_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic             err_q, err_d;

    logic             is_dig, is_mul, is_add, is_sub;
    logic [WIDTH-1:0] dig, n_new, term, val_new, term_cur;

    // Character classification and arithmetic for the candidate results
    always_comb begin
        is_dig   = (in >= 8'h30) && (in <= 8'h39);
        is_mul   = (in == 8'h2A);
        is_add   = (in == 8'h2B);
        is_sub   = (ALLOW_SUB != 0) && (in == 8'h2D);
        dig      = {{(WIDTH-4){1'b0}}, in[3:0]};
        n_new    = (state_q == NUM) ? (n_q * TEN + dig) : dig;
        term     = p_q * n_new;
        val_new  = neg_q ? (s_q - term) : (s_q + term);
        term_cur = p_q * n_q;
    end

    // Next-state and datapath decode for one consumed character
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        p_d     = p_q;
        n_d     = n_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        value_d = value_q;
        err_d   = err_q;
        if (clear) begin
            state_d = IDLE;
            s_d     = '0;
            p_d     = ONE;
            n_d     = '0;
            neg_d   = 1'b0;
            cnt_d   = '0;
            out_d   = 1'b0;
            value_d = '0;
            err_d   = 1'b0;
        end else if (in_valid) begin
            case (state_q)
                IDLE, OP: begin
                    if (is_dig) begin
                        state_d = NUM;
                        n_d     = n_new;
                        cnt_d   = CW'(1);
                        out_d   = 1'b1;
                        value_d = val_new;
                    end else if (state_q == OP) begin
                        state_d = ERR;
                        out_d   = 1'b0;
                        err_d   = 1'b1;
                    end else begin
                        out_d = 1'b0;
                        err_d = 1'b0;
                    end
                end
                NUM: begin
                    if (is_dig && (cnt_q < CW'(MAX_DIGITS))) begin
                        n_d     = n_new;
                        cnt_d   = cnt_q + CW'(1);
                        out_d   = 1'b1;
                        value_d = val_new;
                    end else if (is_mul) begin
                        state_d = OP;
                        p_d     = term_cur;
                        n_d     = '0;
                        cnt_d   = '0;
                        out_d   = 1'b0;
                    end else if (is_add || is_sub) begin
                        state_d = OP;
                        s_d     = neg_q ? (s_q - term_cur) : (s_q + term_cur);
                        p_d     = ONE;
                        n_d     = '0;
                        neg_d   = is_sub;
                        cnt_d   = '0;
                        out_d   = 1'b0;
                    end else begin
                        state_d = ERR;
                        out_d   = 1'b0;
                        err_d   = 1'b1;
                    end
                end
                default: begin
                    state_d = ERR;
                    out_d   = 1'b0;
                    err_d   = 1'b1;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            p_q     <= ONE;
            n_q     <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            value_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            p_q     <= p_d;
            n_q     <= n_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            value_q <= value_d;
            err_q   <= err_d;
        end
    end

    assign out   = out_q;
    assign value = value_q;
    assign err   = err_q;

endmodule

// File: tb/tb_expr_eval.sv
// tb_expr_eval: table-driven check of expr_eval plus reset and
// ALLOW_SUB=0 sequences.
module tb_expr_eval;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in = 8'h00;
    logic        out, out2;
    logic [31:0] value, value2;
    logic        err, err2;

    int n_run = 0;
    int n_fail = 0;

    expr_eval #(.WIDTH(32), .MAX_DIGITS(4), .ALLOW_SUB(1)) dut (
        .clk(clk), .clr_n(clr_n), .clear(clear), .in_valid(in_valid),
        .in(in), .out(out), .value(value), .err(err)
    );

    expr_eval #(.WIDTH(32), .MAX_DIGITS(4), .ALLOW_SUB(0)) dut_nosub (
        .clk(clk), .clr_n(clr_n), .clear(clear), .in_valid(in_valid),
        .in(in), .out(out2), .value(value2), .err(err2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic        vld;
        logic [7:0]  ch;
        logic        eo;
        logic [31:0] ev;
        logic        ee;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        n_run++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic step(input logic c, input logic v, input logic [7:0] ch);
        @(negedge clk);
        clear    = c;
        in_valid = v;
        in       = ch;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic c, input logic v,
                                input logic [7:0] ch, input logic eo,
                                input logic [31:0] ev, input logic ee);
        vec_t t;
        t.clr = c; t.vld = v; t.ch = ch;
        t.eo = eo; t.ev = ev; t.ee = ee;
        tv.push_back(t);
    endfunction

    initial begin
        // precedence: 1+2*3
        add(1, 0, "0", 0, 0, 0);
        add(0, 1, "1", 1, 1, 0);
        add(0, 1, "+", 0, 1, 0);
        add(0, 1, "2", 1, 3, 0);
        add(0, 1, "*", 0, 3, 0);
        add(0, 1, "3", 1, 7, 0);
        // 12*34 with in_valid gaps
        add(1, 0, "0", 0, 0, 0);
        add(0, 1, "1", 1, 1, 0);
        add(0, 0, "9", 1, 1, 0);
        add(0, 1, "2", 1, 12, 0);
        add(0, 1, "*", 0, 12, 0);
        add(0, 0, "+", 0, 12, 0);
        add(0, 1, "3", 1, 36, 0);
        add(0, 0, "x", 1, 36, 0);
        add(0, 1, "4", 1, 408, 0);
        // subtraction wraps
        add(1, 0, "0", 0, 0, 0);
        add(0, 1, "5", 1, 5, 0);
        add(0, 1, "-", 0, 5, 0);
        add(0, 1, "7", 1, 32'hFFFF_FFFE, 0);
        // digit limit and sticky error
        add(1, 0, "0", 0, 0, 0);
        add(0, 1, "1", 1, 1, 0);
        add(0, 1, "2", 1, 12, 0);
        add(0, 1, "3", 1, 123, 0);
        add(0, 1, "4", 1, 1234, 0);
        add(0, 1, "5", 0, 1234, 1);
        add(0, 1, "+", 0, 1234, 1);
        add(0, 1, "1", 0, 1234, 1);
        add(1, 0, "0", 0, 0, 0);
        // leading junk, double operator
        add(0, 1, "a", 0, 0, 0);
        add(0, 1, "3", 1, 3, 0);
        add(0, 1, "+", 0, 3, 0);
        add(0, 1, "+", 0, 3, 1);
        add(1, 0, "0", 0, 0, 0);
        add(0, 1, "x", 0, 0, 0);
        // leading zeros count toward the limit
        add(0, 1, "0", 1, 0, 0);
        add(0, 1, "0", 1, 0, 0);
        add(0, 1, "0", 1, 0, 0);
        add(0, 1, "7", 1, 7, 0);
        add(0, 1, "8", 0, 7, 1);
        // clear wins over in_valid
        add(1, 1, "5", 0, 0, 0);
        add(0, 1, "9", 1, 9, 0);
        add(1, 1, "*", 0, 0, 0);
        // mixed precedence: 2*3+4*5-6 = 20
        add(0, 1, "2", 1, 2, 0);
        add(0, 1, "*", 0, 2, 0);
        add(0, 1, "3", 1, 6, 0);
        add(0, 1, "+", 0, 6, 0);
        add(0, 1, "4", 1, 10, 0);
        add(0, 1, "*", 0, 10, 0);
        add(0, 1, "5", 1, 26, 0);
        add(0, 1, "-", 0, 26, 0);
        add(0, 1, "6", 1, 20, 0);

        // asynchronous reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst out", 32'(out), 0);
        chk("rst value", value, 0);
        chk("rst err", 32'(err), 0);
        @(negedge clk);
        clr_n = 1'b1;

        foreach (tv[i]) begin
            step(tv[i].clr, tv[i].vld, tv[i].ch);
            chk($sformatf("v%0d out", i), 32'(out), 32'(tv[i].eo));
            chk($sformatf("v%0d value", i), value, tv[i].ev);
            chk($sformatf("v%0d err", i), 32'(err), 32'(tv[i].ee));
        end

        // ALLOW_SUB=0: '-' is a syntax error
        step(1, 0, "0");
        step(0, 1, "5");
        chk("nosub 5 out", 32'(out2), 1);
        chk("nosub 5 value", value2, 5);
        step(0, 1, "-");
        chk("nosub - err", 32'(err2), 1);
        chk("nosub - out", 32'(out2), 0);
        step(0, 1, "7");
        chk("nosub 7 err", 32'(err2), 1);
        chk("nosub 7 value", value2, 5);
        chk("sub 7 value", value, 32'hFFFF_FFFE);

        // reset between edges discards partial work
        step(1, 0, "0");
        step(0, 1, "9");
        chk("pre-rst value", value, 9);
        step(0, 1, "*");
        in_valid = 1'b0;
        #2;
        clr_n = 1'b0;
        #1;
        chk("mid-rst out", 32'(out), 0);
        chk("mid-rst value", value, 0);
        chk("mid-rst err", 32'(err), 0);
        @(negedge clk);
        clr_n = 1'b1;
        step(0, 1, "4");
        chk("post-rst out", 32'(out), 1);
        chk("post-rst value", value, 4);
        chk("post-rst err", 32'(err), 0);

        // reset clears a sticky error too
        step(0, 1, "+");
        step(0, 1, "+");
        chk("pre-rst err", 32'(err), 1);
        #2;
        clr_n = 1'b0;
        #1;
        chk("rst err clr", 32'(err), 0);
        @(negedge clk);
        clr_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
